// File: rtl/latency_credit_rx.sv
// rtl/latency_credit_rx.sv - credit-gated receiver for a fixed-latency engine with result FIFO
`timescale 1ns/1ps
module latency_credit_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int LATENCY    = 4,
  parameter int DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_WIDTH-1:0]        s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [DATA_WIDTH-1:0]        issue_data,
  output logic                         issue_valid,
  input  logic [DATA_WIDTH-1:0]        ret_data,
  input  logic                         ret_valid,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [$clog2(DEPTH+1)-1:0]   credits,
  output logic                         err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  generate
    if (LATENCY < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
      $error("latency_credit_rx: LATENCY must be >= 1 and DEPTH a power of two >= 2");
    end
  endgenerate

  logic [CW-1:0]         credits_q, credits_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  s_ready_q, s_ready_d;
  logic                  m_valid_q, m_valid_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  issue, pop, full, wr_en, drop, unexpected;
  logic signed [CW+1:0]  in_flight;

  assign issue_valid = issue;
  assign issue_data  = s_data;
  assign s_ready     = s_ready_q;
  assign m_valid     = m_valid_q;
  assign m_data      = mem[rd_ptr_q];
  assign credits     = credits_q;
  assign err         = err_q;

  always_comb begin
    issue      = s_valid && s_ready_q;
    pop        = m_valid_q && m_ready;
    full       = (count_q == DEPTH_C);
    // Results not backed by a credit push this negative; treat <= 0 as nothing in flight.
    in_flight  = $signed({2'b00, DEPTH_C}) - $signed({2'b00, credits_q}) - $signed({2'b00, count_q});
    wr_en      = ret_valid && (!full || pop);
    drop       = ret_valid && full && !pop;
    unexpected = ret_valid && (in_flight[CW+1] || (in_flight == '0));

    credits_d = credits_q;
    if (issue && !pop) begin
      credits_d = credits_q - CW'(1);
    end else if (pop && !issue && (credits_q != DEPTH_C)) begin
      credits_d = credits_q + CW'(1);
    end

    count_d = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !wr_en) begin
      count_d = count_q - CW'(1);
    end

    wr_ptr_d  = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
    s_ready_d = (credits_d != '0);
    m_valid_d = (count_d != '0);
    err_d     = err_q || drop || unexpected;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_q <= DEPTH_C;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      credits_q <= credits_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= ret_data;
    end
  end

endmodule

// File: tb/tb_latency_credit_rx.sv
// tb/tb_latency_credit_rx.sv - scoreboard bench for latency_credit_rx with a model engine
`timescale 1ns/1ps
module tb_latency_credit_rx;

  localparam int DW  = 8;
  localparam int LAT = 4;
  localparam int DEP = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] issue_data;
  logic          issue_valid;
  logic [DW-1:0] ret_data;
  logic          ret_valid;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic [3:0]    credits;
  logic          err;

  logic          force_v;
  logic [DW-1:0] force_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  latency_credit_rx #(.DATA_WIDTH(DW), .LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .issue_data(issue_data), .issue_valid(issue_valid),
    .ret_data(ret_data), .ret_valid(ret_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .credits(credits), .err(err)
  );

  // Engine: pure LAT-cycle delay line sharing the reset; force_v injects a stray result.
  logic [LAT-1:0] pipe_v;
  logic [DW-1:0]  pipe_d [LAT];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
    end else begin
      pipe_v    <= {pipe_v[LAT-2:0], issue_valid};
      pipe_d[0] <= issue_data;
      for (int i = 1; i < LAT; i++) pipe_d[i] <= pipe_d[i-1];
    end
  end

  assign ret_valid = pipe_v[LAT-1] | force_v;
  assign ret_data  = force_v ? force_d : pipe_d[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: credit pool, FIFO occupancy and sticky error from the block's rules.
  logic [DW-1:0] exp_q [$];
  int            cred_m, occ_m, infl_m;
  bit            err_m, pop_m, iss_m;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cred_m = DEP;
      occ_m  = 0;
      err_m  = 0;
    end else begin
      chk("credits", credits, cred_m);
      chk("s_ready", s_ready, cred_m != 0);
      chk("m_valid", m_valid, occ_m != 0);
      chk("err", err, err_m);
      chk("issue_valid", issue_valid, s_valid && (cred_m != 0));
      pop_m  = (occ_m != 0) && m_ready;
      iss_m  = s_valid && (cred_m != 0);
      infl_m = DEP - cred_m - occ_m;
      if (ret_valid) begin
        if (infl_m <= 0) err_m = 1;
        if (occ_m < DEP || pop_m) begin
          exp_q.push_back(ret_data);
          occ_m++;
        end else begin
          err_m = 1;
        end
      end
      if (pop_m) occ_m--;
      if (iss_m && !pop_m) cred_m--;
      else if (pop_m && !iss_m && cred_m < DEP) cred_m++;
    end
  end

  // Monitor: every accepted output beat must match the oldest expected result.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL m_data_extra: got %0h expected no output at %0t", m_data, $time);
      end else begin
        chk("m_data", m_data, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit iv, pv;
    int n, pops, cyc, first_mv;

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    force_v = 1'b0; force_d = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_credits", credits, DEP);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_issue_valid", issue_valid, 0);
    rst_n = 1'b1;

    // Streaming 0x01..0x20 at full rate
    m_ready = 1'b1; s_valid = 1'b1; n = 0; cyc = 0; first_mv = -1;
    while (n < 32 && cyc < 100) begin
      s_data = 8'(n + 1);
      @(posedge clk); iv = issue_valid; #1;
      cyc++;
      if (iv) n++;
      if (m_valid && first_mv < 0) first_mv = cyc;
    end
    s_valid = 1'b0;
    chk("stream_cycles", cyc, 32);
    chk("stream_first_mvalid", first_mv, LAT + 1);
    repeat (10) step();

    // Downstream stall: exactly DEPTH issues, then drain one credit per pop
    m_ready = 1'b0; s_valid = 1'b1; n = 0;
    repeat (16) begin
      s_data = 8'($urandom);
      @(posedge clk); iv = issue_valid; #1;
      if (iv) n++;
    end
    s_valid = 1'b0;
    chk("stall_issues", n, DEP);
    chk("stall_s_ready", s_ready, 0);
    chk("stall_credits", credits, 0);
    m_ready = 1'b1; pops = 0;
    repeat (12) begin
      @(posedge clk); pv = m_valid && m_ready; #1;
      if (pv) begin
        pops++;
        chk("drain_credits", credits, pops);
      end
    end
    chk("drain_pops", pops, DEP);
    chk("drain_m_valid", m_valid, 0);

    // Full FIFO, then issue and pop every cycle
    m_ready = 1'b0; s_valid = 1'b1;
    repeat (14) begin s_data = 8'($urandom); step(); end
    m_ready = 1'b1;
    step();
    repeat (30) begin
      chk("simul_credits", credits, 1);
      s_data = 8'($urandom);
      step();
    end
    s_valid = 1'b0;
    repeat (12) step();

    // Random traffic
    repeat (400) begin
      s_valid = 1'($urandom % 2);
      s_data  = 8'($urandom);
      m_ready = ($urandom % 4) != 0;
      step();
    end
    s_valid = 1'b0; m_ready = 1'b1;
    repeat (12) step();

    // Stray result with nothing in flight
    force_v = 1'b1; force_d = 8'hA5;
    step();
    force_v = 1'b0;
    chk("unexp_err", err, 1);
    repeat (3) step();
    chk("unexp_err_sticky", err, 1);
    chk("unexp_credits", credits, DEP);

    // Stray result into a full FIFO with no pop is dropped
    m_ready = 1'b0; s_valid = 1'b1;
    repeat (12) begin s_data = 8'($urandom); step(); end
    s_valid = 1'b0;
    repeat (6) step();
    force_v = 1'b1; force_d = 8'h5A;
    step();
    force_v = 1'b0;
    m_ready = 1'b1; pops = 0;
    repeat (12) begin
      @(posedge clk); pv = m_valid && m_ready; #1;
      if (pv) pops++;
    end
    chk("full_drop_pops", pops, DEP);

    // Reset with 3 in flight and 2 buffered
    m_ready = 1'b0; s_valid = 1'b1;
    repeat (5) begin s_data = 8'($urandom); step(); end
    s_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_credits", credits, DEP);
    chk("midrst_s_ready", s_ready, 1);
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_err", err, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) begin
      step();
      chk("post_rst_m_valid", m_valid, 0);
    end
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
